// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: multiplier state encoding, default operand
// width and Booth recoding opcodes.
package cpu_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  // Booth pairs are {Q[0], q_m1}; 00 and 11 leave the accumulator alone.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_unit_if.sv
// Request/result bundle between the control unit and the multiplier.
// mult_op is a request taken only while busy=0; done pulses once per result on hi/lo.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             mult_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mult_op, A, B,
    input  busy, done, hi, lo
  );

  modport slave (
    input  mult_op, A, B,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit_booth.sv
// One radix-2 Booth step: add/subtract M per {Q[0], q_m1}, then arithmetic
// shift of the whole {acc, Q, q_m1} register right by one.
module booth_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]     acc,
  input  logic [WIDTH-1:0]   q,
  input  logic               q_m1,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+1:0] p_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      default:   sum = acc;
    endcase
    // Guard bit keeps -M representable, so replicating sum's MSB is exact.
    p_next = {sum[WIDTH], sum, q};
  end

endmodule

// File: rtl/mult_unit.sv
// Sequential signed multiplier (MULT): one Booth step per clock, result
// latched into hi/lo with a single-cycle done pulse.
module mult_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  mult_unit_if.slave  bus,
  output mult_state_t dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_t        state;
  mult_state_t        next_state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q;
  logic               q_m1;
  logic [WIDTH:0]     m;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;
  logic               busy_c;
  logic [2*WIDTH+1:0] p_next;
  logic               last_step;

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .acc    (acc),
    .q      (q),
    .q_m1   (q_m1),
    .m      (m),
    .p_next (p_next)
  );

  assign last_step = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.mult_op) next_state = ST_RUN;
      ST_RUN:  if (last_step)   next_state = ST_DONE;
      ST_DONE:                  next_state = ST_IDLE;
      default:                  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      m      <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.mult_op) begin
            acc   <= '0;
            q     <= bus.B;
            q_m1  <= 1'b0;
            m     <= {bus.A[WIDTH-1], bus.A};
            count <= '0;
          end
        end
        ST_RUN: begin
          acc   <= p_next[2*WIDTH+1:WIDTH+1];
          q     <= p_next[WIDTH:1];
          q_m1  <= p_next[0];
          count <= count + 1'b1;
        end
        ST_DONE: begin
          // Product is {acc[WIDTH-1:0], Q}; the guard bit is just sign copy.
          hi_r   <= acc[WIDTH-1:0];
          lo_r   <= q;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign dbg_state = state;

endmodule
